// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and FIFO-side signals of the UART TX arbiter
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);
  logic i_enable;
  logic [NUM_REQ-1:0] i_req_valid;
  logic [8*NUM_REQ-1:0] i_req_data;
  logic [NUM_REQ-1:0] i_req_last;
  logic [NUM_REQ-1:0] o_req_ready;
  logic [NUM_REQ-1:0] o_grant;
  logic o_busy;
  logic o_fifo_wr_en;
  logic [7:0] o_fifo_wr_data;
  logic i_fifo_full;
  logic i_err_clear;
  logic o_timeout_error;
  modport master (
    output i_enable, i_req_valid, i_req_data, i_req_last, i_fifo_full, i_err_clear,
    input o_req_ready, o_grant, o_busy, o_fifo_wr_en, o_fifo_wr_data, o_timeout_error
  );
  modport slave (
    input i_enable, i_req_valid, i_req_data, i_req_last, i_fifo_full, i_err_clear,
    output o_req_ready, o_grant, o_busy, o_fifo_wr_en, o_fifo_wr_data, o_timeout_error
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-granular round-robin onto the UART TX FIFO port; UART_TX_ARB_TIMEOUT_EN adds stalled-grant revocation
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic clk,
  input logic rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_n;
  logic [PW-1:0] gidx, gidx_n, ptr, ptr_n, inc;
  logic [NUM_REQ-1:0] grant, ready;
  logic accept, last, wr_en, timeout;
  logic [7:0] wr_data;
  function automatic logic [PW-1:0] pick(input logic [NUM_REQ-1:0] v, input logic [PW-1:0] p);
    int k;
    pick = p;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = (int'(p) + i) % NUM_REQ;
      if (v[k[PW-1:0]]) pick = k[PW-1:0];
    end
  endfunction
  assign ready = (state == LOCKED && !bus.i_fifo_full && !wr_en) ? grant : '0;
  assign accept = |(bus.i_req_valid & ready);
  assign last = |(bus.i_req_valid & ready & bus.i_req_last);
  assign inc = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
  assign bus.o_req_ready = ready;
  assign bus.o_grant = grant;
  assign bus.o_busy = (state == LOCKED);
  assign bus.o_fifo_wr_en = wr_en;
  assign bus.o_fifo_wr_data = wr_data;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt;
  logic err;
  assign timeout = state == LOCKED && !bus.i_req_valid[gidx] && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign bus.o_timeout_error = err;
  always_ff @(posedge clk) begin
    if (rst || state != LOCKED || accept) cnt <= '0;
    else if (!bus.i_req_valid[gidx]) cnt <= cnt + 1'b1;
    if (rst) err <= 1'b0;
    else err <= timeout ? 1'b1 : (bus.i_err_clear ? 1'b0 : err);
  end
`else
  logic unused;
  assign unused = bus.i_err_clear | (TIMEOUT_CYCLES == 0);
  assign timeout = 1'b0;
  assign bus.o_timeout_error = 1'b0;
`endif
  always_comb begin
    state_n = state;
    gidx_n = gidx;
    ptr_n = ptr;
    if (state == IDLE) begin
      if (bus.i_enable && |bus.i_req_valid) begin
        state_n = LOCKED;
        gidx_n = pick(bus.i_req_valid, ptr);
      end
    end else if (last || timeout) begin
      state_n = IDLE;
      ptr_n = inc;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gidx <= '0;
      ptr <= '0;
      grant <= '0;
      wr_en <= 1'b0;
      wr_data <= '0;
    end else begin
      state <= state_n;
      gidx <= gidx_n;
      ptr <= ptr_n;
      grant <= (state_n == LOCKED) ? NUM_REQ'(1) << gidx_n : '0;
      wr_en <= accept;
      if (accept) wr_data <= bus.i_req_data[8*gidx +: 8];
    end
  end
endmodule
